bcd_addsub_serial: RTL and testbench



---
 rtl/bcd_addsub_serial.sv | 195 +++++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD add/subtract with signed-magnitude result and start/busy/done handshake.
// Define BCD_SAT_EN to saturate the result to all 9s on add overflow.
module bcd_addsub_serial #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic [4*DIGITS-1:0]   result,
   output logic                  negative,
   output logic                  overflow,
   output logic                  invalid,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
   logic            op_q, op_d, c_q, c_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d, ovf_q, ovf_d, inv_q, inv_d;
   logic            busy_q, busy_d, done_q, done_d;

   logic [3:0]      ak, bk, rk;
   logic [4:0]      sum5, sub_rhs, neg_rhs;
   logic [3:0]      add_dig, sub_dig, neg_dig, wr_dig;
   logic            add_c, sub_c, neg_c, wr_en, last;

   function automatic logic has_bad(input logic [W-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Per-digit arithmetic on the digit selected by the shared counter
   always_comb begin
      ak      = 4'(a_q >> (4 * cnt_q));
      bk      = 4'(b_q >> (4 * cnt_q));
      rk      = 4'(result_q >> (4 * cnt_q));
      last    = (cnt_q == CW'(DIGITS - 1));

      sum5    = 5'(ak) + 5'(bk) + 5'(c_q);
      add_c   = (sum5 > 5'd9);
      add_dig = add_c ? 4'(sum5 - 5'd10) : sum5[3:0];

      sub_rhs = 5'(bk) + 5'(c_q);
      sub_c   = (5'(ak) < sub_rhs);
      sub_dig = 4'(5'(ak) + (sub_c ? 5'd10 : 5'd0) - sub_rhs);

      neg_rhs = 5'(rk) + 5'(c_q);
      neg_c   = (neg_rhs != 5'd0);
      neg_dig = 4'((neg_c ? 5'd10 : 5'd0) - neg_rhs);
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      inv_d    = inv_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wr_en    = 1'b0;
      wr_dig   = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               op_d  = op;
               neg_d = 1'b0;
               ovf_d = 1'b0;
               cnt_d = '0;
               c_d   = 1'b0;
               if (has_bad(a) || has_bad(b)) begin
                  result_d = '1;
                  inv_d    = 1'b1;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end else begin
                  result_d = '0;
                  inv_d    = 1'b0;
                  busy_d   = 1'b1;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            wr_en  = 1'b1;
            wr_dig = op_q ? sub_dig : add_dig;
            c_d    = op_q ? sub_c : add_c;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               cnt_d = '0;
               if (op_q && sub_c) begin
                  // Borrow out: result holds the ten's complement, negate it digit-serially
                  c_d     = 1'b0;
                  state_d = NEG;
               end else begin
                  c_d     = 1'b0;
                  ovf_d   = !op_q && add_c;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         NEG: begin
            wr_en  = 1'b1;
            wr_dig = neg_dig;
            c_d    = neg_c;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               cnt_d   = '0;
               c_d     = 1'b0;
               neg_d   = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (wr_en) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) result_d[4*i +: 4] = wr_dig;
         end
      end

`ifdef BCD_SAT_EN
      if (state_q == RUN && last && !op_q && add_c) result_d = {DIGITS{4'h9}};
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         inv_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         inv_q    <= inv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result   = result_q;
   assign negative = neg_q;
   assign overflow = ovf_q;
   assign invalid  = inv_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomised and directed bench for bcd_addsub_serial (DIGITS=4) against an integer-arithmetic model.
module tb_bcd_addsub_serial;

   localparam int D   = 4;
   localparam int POW = 10000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [15:0] result;
   logic        negative, overflow, invalid, busy, done;

   int vectors = 0;
   int errors  = 0;

   bcd_addsub_serial #(.DIGITS(D)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .result(result), .negative(negative), .overflow(overflow),
      .invalid(invalid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   function automatic int bcd2int(input logic [15:0] x);
      int v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic any_bad(input logic [15:0] x);
      logic bad = 1'b0;
      for (int i = 0; i < 4; i++) if (x[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   // lat = clock edges after the accepting edge until done is seen high
   task automatic model(input logic [15:0] ma, mb, input logic mop,
                        output logic [15:0] er, output logic en, eo, ei, output int el);
      int s;
      en = 1'b0; eo = 1'b0; ei = 1'b0;
      if (any_bad(ma) || any_bad(mb)) begin
         er = 16'hFFFF; ei = 1'b1; el = 0;
      end else if (!mop) begin
         s  = bcd2int(ma) + bcd2int(mb);
         eo = (s >= POW);
`ifdef BCD_SAT_EN
         er = eo ? int2bcd(POW - 1) : int2bcd(s);
`else
         er = int2bcd(s % POW);
`endif
         el = D;
      end else begin
         s  = bcd2int(ma) - bcd2int(mb);
         en = (s < 0);
         er = int2bcd(en ? -s : s);
         el = en ? 2 * D : D;
      end
   endtask

   task automatic do_op(input logic [15:0] ta, tbv, input logic top,
                        output int lat, output logic busy_seen);
      a = ta; b = tbv; op = top; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_seen = busy;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         busy_seen = busy_seen | busy;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
      vectors++;
      if ({negative, overflow, invalid, busy, done} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000", {negative, overflow, invalid, busy, done});
      end
      vectors++;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_checked(input string tag, input logic [15:0] ta, tbv, input logic top);
      logic [15:0] er, held; logic en, eo, ei, bs; int el, lat;
      model(ta, tbv, top, er, en, eo, ei, el);
      do_op(ta, tbv, top, lat, bs);
      if (lat !== el) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, lat, el); end
      vectors++;
      if (result !== er) begin errors++; $display("FAIL %s_result: got %h expected %h", tag, result, er); end
      vectors++;
      if ({negative, overflow, invalid} !== {en, eo, ei}) begin
         errors++; $display("FAIL %s_flags: got n/o/i=%b expected %b", tag, {negative, overflow, invalid}, {en, eo, ei});
      end
      vectors++;
      if (bs !== !ei) begin errors++; $display("FAIL %s_busy: got %b expected %b", tag, bs, !ei); end
      vectors++;
      held = result;
      a = 16'(  $urandom); b = 16'($urandom); op = 1'($urandom);
      repeat (2) begin @(posedge clk); #1; end
      if (done !== 1'b0 || result !== er) begin
         errors++; $display("FAIL %s_hold: got done=%b result=%h expected done=0 result=%h", tag, done, result, er);
      end
      vectors++;
      if (held !== er) ; // held only mirrors the earlier sample
   endtask

   task automatic test_directed;
      run_checked("add_1234_5678", 16'h1234, 16'h5678, 1'b0);
      run_checked("add_9999_0001", 16'h9999, 16'h0001, 1'b0);
      run_checked("sub_0100_0250", 16'h0100, 16'h0250, 1'b1);
      run_checked("sub_0500_0500", 16'h0500, 16'h0500, 1'b1);
      run_checked("inv_12A4_0001", 16'h12A4, 16'h0001, 1'b0);
      run_checked("sub_0000_9999", 16'h0000, 16'h9999, 1'b1);
      run_checked("inv_b_sub",     16'h0001, 16'hF000, 1'b1);
   endtask

   task automatic test_random;
      logic [15:0] ra, rb;
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 4; k++) begin
            ra[4*k +: 4] = 4'($urandom_range(0, 9));
            rb[4*k +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         run_checked($sformatf("rnd%0d", i), ra, rb, 1'($urandom));
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic bs;
      a = 16'h0999; b = 16'h0001; op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h2222; op = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 2;
      while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
      if (lat !== D) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, D); end
      vectors++;
      if (result !== 16'h1000 || negative !== 1'b0) begin
         errors++; $display("FAIL b2b_result: got %h neg=%b expected 1000 neg=0", result, negative);
      end
      vectors++;
      a = 16'h0007; b = 16'h0001; op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h1000) begin
         errors++; $display("FAIL b2b_start_in_done: got busy=%b done=%b result=%h expected 0 0 1000", busy, done, result);
      end
      vectors++;
      do_op(16'h0002, 16'h0003, 1'b0, lat, bs);
      if (lat !== D || result !== 16'h0005) begin
         errors++; $display("FAIL b2b_next: got lat=%0d result=%h expected lat=%0d result=0005", lat, result, D);
      end
      vectors++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      int lat, done_hits; logic bs;
      a = 16'h5000; b = 16'h6000; op = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      if (result !== 16'h0 || {negative, overflow, invalid, busy, done} !== 5'b0) begin
         errors++; $display("FAIL abort_outputs: got result=%h flags=%b expected 0000 00000",
                            result, {negative, overflow, invalid, busy, done});
      end
      vectors++;
      done_hits = 0;
      repeat (12) begin @(posedge clk); #1; if (done) done_hits++; end
      if (done_hits !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_hits); end
      vectors++;
      do_op(16'h0001, 16'h0001, 1'b0, lat, bs);
      if (lat !== D || result !== 16'h0002 || bs !== 1'b1) begin
         errors++; $display("FAIL abort_recover: got lat=%0d result=%h busy=%b expected lat=%0d result=0002 busy=1",
                            lat, result, bs, D);
      end
      vectors++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
